// File: rtl/if_id_queue.sv
// FWFT fetch->decode instruction queue: (pc, instr, adel) entries, one-cycle
// redirect flush, registered f_ready so the hazard stall never reaches fetch combinationally.

module if_id_queue_slot #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Payload only; validity lives in the queue's count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (we) q <= d;
  end
endmodule

module if_id_queue #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       f_valid,
  output logic                       f_ready,
  input  logic [31:0]                f_pc,
  input  logic [31:0]                f_instr,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [31:0]                d_pc,
  output logic [31:0]                d_pc_plus4,
  output logic [31:0]                d_instr,
  output logic                       d_adel,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic [AW-1:0]             head, tail;
  logic [CW-1:0]             count;
  logic [DEPTH-1:0][EW-1:0]  slot_q;
  logic [DEPTH-1:0]          slot_we;
  entry_t                    wr_entry, head_entry;
  logic                      push, pop;

  assign f_ready = (count != CW'(DEPTH));
  assign d_valid = (count != '0);

  // A flush cycle discards any handshake, so neither pointer nor storage moves.
  assign push = f_valid & f_ready & ~flush;
  assign pop  = d_valid & d_ready & ~flush;

  assign wr_entry.pc    = f_pc;
  assign wr_entry.instr = f_instr;
  assign wr_entry.adel  = |f_pc[1:0];

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign slot_we[i] = push && (tail == AW'(i));
    if_id_queue_slot #(.W(EW)) u_slot (
      .clk (clk),
      .we  (slot_we[i]),
      .d   (wr_entry),
      .q   (slot_q[i])
    );
  end

  assign head_entry = entry_t'(slot_q[head]);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Empty queue presents zeros; instr 0 is a NOP to decode.
  assign d_pc       = d_valid ? head_entry.pc : '0;
  assign d_pc_plus4 = d_valid ? head_entry.pc + 32'd4 : '0;
  assign d_instr    = d_valid ? head_entry.instr : '0;
  assign d_adel     = d_valid & head_entry.adel;
  assign occupancy  = count;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table, streaming sequence, and
// randomized traffic against a queue-based reference model.

module tb_if_id_queue;
  localparam int DEPTH = 2;
  localparam int OW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, flush, f_valid, d_ready;
  logic [31:0]   f_pc, f_instr;
  logic          f_ready, d_valid, d_adel;
  logic [31:0]   d_pc, d_pc_plus4, d_instr;
  logic [OW-1:0] occupancy;

  int tests = 0;
  int fails = 0;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .f_valid    (f_valid),
    .f_ready    (f_ready),
    .f_pc       (f_pc),
    .f_instr    (f_instr),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .d_pc       (d_pc),
    .d_pc_plus4 (d_pc_plus4),
    .d_instr    (d_instr),
    .d_adel     (d_adel),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, fl, fv, dr;
    logic [31:0] pc;
    logic        ev, efr;
    int          eocc;
    logic [31:0] epc;
    logic        eadel;
  } vec_t;

  typedef struct {
    logic [31:0] pc, instr;
    logic        adel;
  } ent_t;

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'h2400_A5A5;
  endfunction

  function automatic vec_t mk(input logic rst, fl, fv, dr, input logic [31:0] pc,
                              input logic ev, efr, input int eocc,
                              input logic [31:0] epc, input logic eadel);
    vec_t v;
    v.rst = rst; v.fl = fl; v.fv = fv; v.dr = dr; v.pc = pc;
    v.ev = ev; v.efr = efr; v.eocc = eocc; v.epc = epc; v.eadel = eadel;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares every output against an expected head entry (or the empty state).
  task automatic chk_all(input string tag, input logic ev, efr, input int eocc,
                         input logic [31:0] epc, einstr, input logic eadel);
    chk({tag, ".d_valid"},    32'(d_valid),    32'(ev));
    chk({tag, ".f_ready"},    32'(f_ready),    32'(efr));
    chk({tag, ".occupancy"},  32'(occupancy),  32'(eocc));
    chk({tag, ".d_pc"},       d_pc,            ev ? epc : 32'd0);
    chk({tag, ".d_pc_plus4"}, d_pc_plus4,      ev ? epc + 32'd4 : 32'd0);
    chk({tag, ".d_instr"},    d_instr,         ev ? einstr : 32'd0);
    chk({tag, ".d_adel"},     32'(d_adel),     32'(ev & eadel));
  endtask

  task automatic drive(input logic rst, fl, fv, dr, input logic [31:0] pc, instr);
    reset = rst; flush = fl; f_valid = fv; d_ready = dr; f_pc = pc; f_instr = instr;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  ent_t mq[$];

  initial begin
    reset = 1'b1; flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
    f_pc = '0; f_instr = '0;

    // rst fl fv dr pc | ev efr occ epc adel
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h00400000, 1, 1, 1, 32'h00400000, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h00400004, 1, 0, 2, 32'h00400000, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h00400008, 1, 0, 2, 32'h00400000, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h00400008, 1, 1, 1, 32'h00400004, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h00400008, 1, 0, 2, 32'h00400004, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,        1, 1, 1, 32'h00400008, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,        0, 1, 0, 32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h00400010, 1, 1, 1, 32'h00400010, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h00400014, 1, 0, 2, 32'h00400010, 0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h00400100, 0, 1, 0, 32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h00400200, 1, 1, 1, 32'h00400200, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h00400002, 1, 1, 1, 32'h00400002, 1));
    vecs.push_back(mk(0, 0, 1, 1, 32'h00400004, 1, 1, 1, 32'h00400004, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h00400008, 1, 0, 2, 32'h00400004, 0));
    vecs.push_back(mk(1, 1, 1, 1, 32'h0040000C, 0, 1, 0, 32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].fv, vecs[i].dr, vecs[i].pc, ins_of(vecs[i].pc));
      chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].efr, vecs[i].eocc,
              vecs[i].epc, ins_of(vecs[i].epc), vecs[i].eadel);
    end

    // Streaming across several pointer wraps: occupancy pinned at 1.
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] pc;
      pc = 32'h00400000 + 32'(4 * i);
      drive(0, 0, 1, 1, pc, ins_of(pc));
      chk_all($sformatf("stream%0d", i), 1'b1, 1'b1, 1, pc, ins_of(pc), 1'b0);
    end
    drive(0, 0, 0, 1, 32'h0, 32'h0);
    chk_all("stream_drain", 1'b0, 1'b1, 0, 32'h0, 32'h0, 1'b0);

    // Randomized traffic against a plain FIFO model.
    drive(1, 0, 0, 0, 32'h0, 32'h0);
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      logic rst, fl, fv, dr;
      logic [31:0] pc, instr;
      ent_t e;
      rst   = ($urandom_range(99) < 2);
      fl    = ($urandom_range(99) < 6);
      fv    = ($urandom_range(99) < 60);
      dr    = ($urandom_range(99) < 55);
      pc    = {$urandom_range(32'hFFFF), 14'd0, 2'($urandom_range(3))} ^ 32'h00400000;
      instr = $urandom;
      if (rst || fl) begin
        mq.delete();
      end else begin
        bit can_push, can_pop;
        can_push = fv && (mq.size() < DEPTH);
        can_pop  = dr && (mq.size() > 0);
        if (can_pop) void'(mq.pop_front());
        if (can_push) begin
          e.pc = pc; e.instr = instr; e.adel = (pc % 4) != 0;
          mq.push_back(e);
        end
      end
      drive(rst, fl, fv, dr, pc, instr);
      if (mq.size() > 0)
        chk_all($sformatf("rnd%0d", c), 1'b1, mq.size() < DEPTH, mq.size(),
                mq[0].pc, mq[0].instr, mq[0].adel);
      else
        chk_all($sformatf("rnd%0d", c), 1'b0, 1'b1, 0, 32'h0, 32'h0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
